hazard_stall_ctrl: RTL and testbench

//  Stall/flush controller for the 5-stage MIPS pipeline. Drives the PC enable, the IF_ID

---
 rtl/hazard_stall_ctrl.sv | 85 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush control for the 5-stage pipeline: RAW Tuse/Tnew scoreboard for E/M plus optional MDU busy counter (HAZ_MDU_EN).
// Latency: stall/enables are combinational on the D-stage inputs; scoreboard and MDU counter update on each rising edge.
// Backpressure: a stall holds PC and IF_ID and turns the instruction entering E into a bubble.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] a3_D,
  input  logic [1:0] tnew_D,
  input  logic       md_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  output logic       en_F,
  output logic       en_D,
  output logic       flush_E,
  output logic [4:0] a3_E,
  output logic [4:0] a3_M,
  output logic [1:0] tnew_E,
  output logic [1:0] tnew_M,
  output logic       md_busy
);

  logic hz_rs;
  logic hz_rt;
  logic md_stall;
  logic stall;

  // $0 is never a real dependency and Tuse 3 means the operand is not read.
  assign hz_rs = (rs_D != 5'd0) && (tuse_rs_D != 2'd3) &&
                 (((rs_D == a3_E) && (tnew_E > tuse_rs_D)) ||
                  ((rs_D == a3_M) && (tnew_M > tuse_rs_D)));
  assign hz_rt = (rt_D != 5'd0) && (tuse_rt_D != 2'd3) &&
                 (((rt_D == a3_E) && (tnew_E > tuse_rt_D)) ||
                  ((rt_D == a3_M) && (tnew_M > tuse_rt_D)));

  assign stall   = hz_rs | hz_rt | md_stall;
  assign en_F    = ~stall;
  assign en_D    = ~stall;
  assign flush_E = stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3_E   <= 5'd0;
      tnew_E <= 2'd0;
      a3_M   <= 5'd0;
      tnew_M <= 2'd0;
    end else begin
      a3_E   <= stall ? 5'd0 : a3_D;
      tnew_E <= stall ? 2'd0 : tnew_D;
      a3_M   <= a3_E;
      tnew_M <= (tnew_E == 2'd0) ? 2'd0 : tnew_E - 2'd1;
    end
  end

`ifdef HAZ_MDU_EN
  localparam int CW = $clog2(DIV_CYCLES + 1);
  logic [CW-1:0] md_cnt;

  // A start is only accepted when md_cnt is already zero, so load and decrement never overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt <= '0;
    end else if (!stall && md_start_D) begin
      md_cnt <= md_div_D ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CW'(1);
    end
  end

  assign md_busy  = (md_cnt != '0);
  assign md_stall = md_D && md_busy;
`else
  logic unused_md;
  assign unused_md = ^{md_D, md_start_D, md_div_D};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed pipeline scenarios plus random D-stage traffic against a cycle-history model.
module tb_hazard_stall_ctrl;
  localparam int MULTC = 5;
  localparam int DIVC  = 10;
`ifdef HAZ_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
  logic       md_D, md_start_D, md_div_D;
  logic       en_F, en_D, flush_E, md_busy;
  logic [4:0] a3_E, a3_M;
  logic [1:0] tnew_E, tnew_M;

  int n_run  = 0;
  int n_fail = 0;

  // Model: the last two accepted instructions by age (1 = entered E last edge), and the last MDU busy cycle.
  bit         h_vld[1:2];
  logic [4:0] h_a3[1:2];
  logic [1:0] h_tn[1:2];
  int         cyc = 0;
  int         busy_end = -1;

  hazard_stall_ctrl #(.MULT_CYCLES(MULTC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .a3_D(a3_D), .tnew_D(tnew_D), .md_D(md_D), .md_start_D(md_start_D), .md_div_D(md_div_D),
    .en_F(en_F), .en_D(en_D), .flush_E(flush_E),
    .a3_E(a3_E), .a3_M(a3_M), .tnew_E(tnew_E), .tnew_M(tnew_M), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_hz(input logic [4:0] r, input logic [1:0] tuse);
    m_hz = 1'b0;
    if (r != 0 && tuse != 2'd3)
      for (int age = 1; age <= 2; age++)
        if (h_vld[age] && h_a3[age] == r && (int'(h_tn[age]) - (age - 1)) > int'(tuse))
          m_hz = 1'b1;
  endfunction

  function automatic bit m_busy();
    m_busy = MDU && (cyc <= busy_end);
  endfunction

  function automatic bit m_stall();
    m_stall = m_hz(rs_D, tuse_rs_D) | m_hz(rt_D, tuse_rt_D) | (md_D && m_busy());
  endfunction

  function automatic logic [13:0] m_sb();
    logic [4:0] ea3e, ea3m;
    logic [1:0] etne, etnm;
    ea3e = h_vld[1] ? h_a3[1] : 5'd0;
    etne = h_vld[1] ? h_tn[1] : 2'd0;
    ea3m = h_vld[2] ? h_a3[2] : 5'd0;
    etnm = (h_vld[2] && h_tn[2] != 0) ? h_tn[2] - 2'd1 : 2'd0;
    m_sb = {ea3e, etne, ea3m, etnm};
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [1:0] trs, input logic [4:0] rt,
                       input logic [1:0] trt, input logic [4:0] a3, input logic [1:0] tn,
                       input logic md, input logic ms, input logic mdv);
    rs_D = rs; tuse_rs_D = trs; rt_D = rt; tuse_rt_D = trt;
    a3_D = a3; tnew_D = tn; md_D = md; md_start_D = ms; md_div_D = mdv;
    #1;
  endtask

  task automatic nop();
    drive(0, 3, 0, 3, 0, 0, 0, 0, 0);
  endtask

  task automatic m_clear();
    h_vld[1] = 0; h_vld[2] = 0;
    busy_end = -1;
  endtask

  task automatic tick();
    bit acc;
    acc = !m_stall();
    @(posedge clk);
    h_vld[2] = h_vld[1]; h_a3[2] = h_a3[1]; h_tn[2] = h_tn[1];
    h_vld[1] = acc;      h_a3[1] = a3_D;    h_tn[1] = tnew_D;
    if (MDU && acc && md_start_D) busy_end = cyc + (md_div_D ? DIVC : MULTC);
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (12) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    nop();
    m_clear();
    repeat (2) @(negedge clk);
    #1;
    n_run++;
    if ({en_F, en_D, flush_E, md_busy} !== 4'b1100) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 1100", {en_F, en_D, flush_E, md_busy});
    end
    n_run++;
    if ({a3_E, tnew_E, a3_M, tnew_M} !== 14'd0) begin
      n_fail++; $display("FAIL reset_sb: got %h want 0", {a3_E, tnew_E, a3_M, tnew_M});
    end
    reset = 1'b1;
    #1;
  endtask

  // Feed a consumer and count stall cycles until it is accepted.
  task automatic count_stalls(input string name, input int exp);
    int n = 0;
    for (int i = 0; i < 20; i++) begin
      if (en_D !== 1'b0) break;
      n++;
      n_run++;
      if (flush_E !== 1'b1 || en_F !== 1'b0) begin
        n_fail++; $display("FAIL %s_flush: got flush_E=%b en_F=%b want 1/0", name, flush_E, en_F);
      end
      tick();
    end
    n_run++;
    if (n != exp) begin
      n_fail++; $display("FAIL %s_stalls: got %0d want %0d", name, n, exp);
    end
  endtask

  task automatic test_lw_beq();
    drain();
    drive(0, 3, 0, 3, 8, 2, 0, 0, 0);
    tick();
    drive(8, 0, 0, 3, 0, 0, 0, 0, 0);
    count_stalls("lw_beq", 2);
  endtask

  task automatic test_lw_add();
    drain();
    drive(0, 3, 0, 3, 8, 2, 0, 0, 0);
    tick();
    drive(8, 1, 0, 3, 9, 1, 0, 0, 0);
    count_stalls("lw_add", 1);
    drain();
    drive(0, 3, 0, 3, 8, 2, 0, 0, 0);
    tick();
    drive(0, 3, 8, 3, 9, 1, 0, 0, 0);
    count_stalls("lw_noread", 0);
  endtask

  task automatic test_zero_reg();
    drain();
    drive(0, 3, 0, 3, 0, 2, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_run++;
    if (en_D !== 1'b1 || a3_E !== 5'd0) begin
      n_fail++; $display("FAIL zero_reg: got en_D=%b a3_E=%0d want 1/0", en_D, a3_E);
    end
  endtask

  task automatic test_mdu(input bit is_div);
    int nb = 0;
    drain();
    drive(0, 3, 0, 3, 0, 0, 1, 1, is_div);
    tick();
    for (int i = 0; i < 20; i++) begin
      if (md_busy === 1'b1) nb++;
      if (md_busy !== 1'b1) break;
      tick();
    end
    n_run++;
    if (nb != (MDU ? (is_div ? DIVC : MULTC) : 0)) begin
      n_fail++; $display("FAIL mdu_busy_len div=%0d: got %0d want %0d", is_div, nb, MDU ? (is_div ? DIVC : MULTC) : 0);
    end
    drain();
    drive(0, 3, 0, 3, 0, 0, 1, 1, is_div);
    tick();
    drive(0, 3, 0, 3, 2, 2, 1, 0, 0);
    count_stalls(is_div ? "mflo_div" : "mflo_mult", MDU ? (is_div ? DIVC : MULTC) : 0);
  endtask

  task automatic test_reset_mid_div();
    drain();
    drive(0, 3, 0, 3, 0, 0, 1, 1, 1);
    tick();
    drive(0, 3, 0, 3, 6, 2, 0, 0, 0);
    tick();
    drive(0, 3, 0, 3, 5, 1, 0, 0, 0);
    tick();
    drive(0, 3, 0, 3, 0, 0, 1, 0, 0);
    n_run++;
    if ({md_busy, en_D, a3_E, a3_M} !== {MDU, ~MDU, 5'd5, 5'd6}) begin
      n_fail++; $display("FAIL pre_reset: got %h want %h", {md_busy, en_D, a3_E, a3_M}, {MDU, ~MDU, 5'd5, 5'd6});
    end
    reset = 1'b0;
    #1;
    n_run++;
    if ({md_busy, en_D, flush_E, a3_E, a3_M} !== {3'b010, 10'd0}) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", {md_busy, en_D, flush_E, a3_E, a3_M}, {3'b010, 10'd0});
    end
    m_clear();
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_raw_and_mdu();
    drain();
    drive(0, 3, 0, 3, 0, 0, 1, 1, 0);
    tick();
    drive(0, 3, 0, 3, 9, 2, 0, 0, 0);
    tick();
    drive(9, 0, 0, 3, 3, 1, 1, 0, 0);
    count_stalls("raw_mdu", MDU ? 4 : 2);
    n_run++;
    if (en_D !== 1'b1) begin
      n_fail++; $display("FAIL raw_mdu_release: got en_D=%b want 1", en_D);
    end
  endtask

  task automatic test_random();
    bit s;
    logic md;
    drain();
    for (int i = 0; i < 600; i++) begin
      md = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, 2), md, md & $urandom_range(0, 1), $urandom_range(0, 1));
      s = m_stall();
      n_run++;
      if ({en_F, en_D, flush_E} !== {~s, ~s, s}) begin
        n_fail++; $display("FAIL rnd_ctrl cyc %0d: got %b want %b", cyc, {en_F, en_D, flush_E}, {~s, ~s, s});
      end
      n_run++;
      if (md_busy !== m_busy()) begin
        n_fail++; $display("FAIL rnd_busy cyc %0d: got %b want %b", cyc, md_busy, m_busy());
      end
      n_run++;
      if ({a3_E, tnew_E, a3_M, tnew_M} !== m_sb()) begin
        n_fail++; $display("FAIL rnd_sb cyc %0d: got %h want %h", cyc, {a3_E, tnew_E, a3_M, tnew_M}, m_sb());
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    nop();
    m_clear();
    @(negedge clk);
    test_reset();
    test_lw_beq();
    test_lw_add();
    test_zero_reg();
    test_mdu(1'b0);
    test_mdu(1'b1);
    test_reset_mid_div();
    test_raw_and_mdu();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
